// File: rtl/fpu_pipe_issue.sv
// Issue/return wrapper for a fixed-latency fadd pipeline: credit-limited issue, in-order result FIFO.
// Optional same-cycle result bypass when FPU_PIPE_ISSUE_BYPASS_EN is defined.
`timescale 1ns/1ps
module fpu_pipe_issue #(
   parameter int LATENCY = 2,
   parameter int DEPTH   = 4,
   parameter int TAG_W   = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [31:0]      req_x,
   input  logic [31:0]      req_y,
   input  logic [TAG_W-1:0] req_tag,
   output logic [31:0]      pipe_x,
   output logic [31:0]      pipe_y,
   input  logic [31:0]      pipe_res,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [31:0]      rsp_data,
   output logic [TAG_W-1:0] rsp_tag,
   output logic             busy
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   // Bit i holds the operation fired i+1 cycles ago.
   logic [LATENCY-1:0] stg_vld_q;
   logic [TAG_W-1:0]   stg_tag_q [LATENCY];
   logic [31:0]        mem_data_q [DEPTH];
   logic [TAG_W-1:0]   mem_tag_q [DEPTH];
   logic [PW-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0]      fcnt_q, fcnt_d, cnt_q, cnt_d;
   logic               fire, pop, arrive, fifo_empty, fifo_wr, fifo_rd;
   logic [TAG_W-1:0]   arr_tag;

   assign pipe_x     = req_x;
   assign pipe_y     = req_y;
   assign req_ready  = (cnt_q < CW'(DEPTH)) & ~rst;
   assign fire       = req_valid & req_ready;
   assign arrive     = stg_vld_q[LATENCY-1];
   assign arr_tag    = stg_tag_q[LATENCY-1];
   assign fifo_empty = (fcnt_q == '0);
   assign busy       = (cnt_q != '0);
   assign pop        = rsp_valid & rsp_ready;

`ifdef FPU_PIPE_ISSUE_BYPASS_EN
   // An arriving result is presented directly when the buffer is empty; it is
   // only stored if the consumer does not take it in the same cycle.
   always_comb begin
      rsp_valid = ~fifo_empty | arrive;
      rsp_data  = fifo_empty ? pipe_res : mem_data_q[rptr_q];
      rsp_tag   = fifo_empty ? arr_tag  : mem_tag_q[rptr_q];
   end
   assign fifo_wr = arrive & ~(fifo_empty & rsp_ready);
   assign fifo_rd = pop & ~fifo_empty;
`else
   always_comb begin
      rsp_valid = ~fifo_empty;
      rsp_data  = mem_data_q[rptr_q];
      rsp_tag   = mem_tag_q[rptr_q];
   end
   assign fifo_wr = arrive;
   assign fifo_rd = pop;
`endif

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (fifo_wr) wptr_d = (wptr_q == PW'(DEPTH - 1)) ? '0 : wptr_q + PW'(1);
      if (fifo_rd) rptr_d = (rptr_q == PW'(DEPTH - 1)) ? '0 : rptr_q + PW'(1);
      fcnt_d = fcnt_q + CW'(fifo_wr) - CW'(fifo_rd);
      cnt_d  = cnt_q + CW'(fire) - CW'(pop);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stg_vld_q <= '0;
         wptr_q    <= '0;
         rptr_q    <= '0;
         fcnt_q    <= '0;
         cnt_q     <= '0;
      end else begin
         stg_vld_q[0] <= fire;
         for (int unsigned i = 1; i < LATENCY; i++) stg_vld_q[i] <= stg_vld_q[i-1];
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         fcnt_q <= fcnt_d;
         cnt_q  <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      stg_tag_q[0] <= req_tag;
      for (int unsigned i = 1; i < LATENCY; i++) stg_tag_q[i] <= stg_tag_q[i-1];
      if (fifo_wr) begin
         mem_data_q[wptr_q] <= pipe_res;
         mem_tag_q[wptr_q]  <= arr_tag;
      end
   end

endmodule
